// File: rtl/pb_spi_multi.sv
`default_nettype none
// ============================================================================
//  Module   : pb_spi_multi
//  Purpose  : PicoBlaze port-bus SPI master with TX/RX FIFOs, all four
//             CPOL/CPHA modes, MSB/LSB-first framing, programmable SCK
//             divider and up to eight chip selects with automatic assertion.
//  Ports    : clk, reset                  - clock, synchronous active-high reset
//             port_id, data_in, data_out  - PicoBlaze port bus (registered read)
//             read_strobe, write_strobe   - one-cycle bus qualifiers
//             interrupt                   - registered level interrupt
//             sck_o, mosi_o, miso_i       - SPI bus
//             ncs_o[NCS-1:0]              - active-low chip selects
//  Revision : 1.0 - initial release
// ============================================================================
module pb_spi_multi #(
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter int         FIFO_DEPTH   = 4,
    parameter int         NCS          = 2,
    parameter logic [7:0] DIV_RESET    = 8'd3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     port_id,
    input  logic [7:0]     data_in,
    output logic [7:0]     data_out,
    input  logic           read_strobe,
    input  logic           write_strobe,
    output logic           interrupt,
    output logic           sck_o,
    output logic           mosi_o,
    input  logic           miso_i,
    output logic [NCS-1:0] ncs_o
);
    localparam int              c_aw   = $clog2(FIFO_DEPTH);
    localparam int              c_cw   = c_aw + 1;
    localparam logic [c_cw-1:0] c_full = c_cw'(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;

    localparam logic [7:0] c_a_ctrl = BASE_ADDRESS;
    localparam logic [7:0] c_a_div  = BASE_ADDRESS + 8'd1;
    localparam logic [7:0] c_a_cs   = BASE_ADDRESS + 8'd2;
    localparam logic [7:0] c_a_stat = BASE_ADDRESS + 8'd3;
    localparam logic [7:0] c_a_data = BASE_ADDRESS + 8'd4;

    // Registers
    logic [6:0] r_ctrl;
    logic [7:0] r_div;
    logic [2:0] r_cs_sel;
    logic       r_cs_force;
    logic       r_tx_ovf, r_done, r_rx_ovf;
    logic [7:0] r_data_out;
    logic       r_irq;

    // FIFOs
    logic [7:0]      r_tx_mem [FIFO_DEPTH];
    logic [7:0]      r_rx_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [c_cw-1:0] r_tx_cnt, r_rx_cnt;

    // Engine
    logic [1:0] r_state;
    logic [7:0] r_tx_sr, r_rx_sr;
    logic [7:0] r_hp_cnt, r_div_l;
    logic [3:0] r_hp_idx;
    logic       r_cpha_l, r_lsb_l;
    logic       r_sck, r_mosi;

    logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_busy;
    logic       w_wr_data, w_wr_stat, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic       w_tx_ovf_set, w_rx_ovf_set, w_done_set;
    logic       w_tc, w_last, w_leading, w_sample, w_shift;
    logic [7:0] w_rx_byte, w_status, w_rd_mux;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == c_full);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_full);
    assign w_busy     = (r_state != c_st_idle) || (r_ctrl[0] && !w_tx_empty);

    assign w_wr_data    = write_strobe && (port_id == c_a_data);
    assign w_wr_stat    = write_strobe && (port_id == c_a_stat);
    assign w_tx_push    = w_wr_data && !w_tx_full;
    assign w_tx_ovf_set = w_wr_data && w_tx_full;
    assign w_tx_pop     = (r_state == c_st_load);
    assign w_rx_pop     = read_strobe && (port_id == c_a_data) && !w_rx_empty;

    // Half-period bookkeeping: even half-period index ends on a leading edge.
    assign w_tc      = (r_state == c_st_shift) && (r_hp_cnt == r_div_l);
    assign w_last    = w_tc && (r_hp_idx == 4'd15);
    assign w_leading = ~r_hp_idx[0];
    assign w_sample  = w_tc && (r_cpha_l ? ~w_leading : w_leading);
    // CPHA=1 holds the bit presented in LOAD across the first leading edge.
    assign w_shift   = w_tc && (r_cpha_l ? (w_leading && (r_hp_idx != 4'd0)) : ~w_leading);

    // Final CPHA=1 sample lands on the same cycle as the RX push.
    always_comb begin
        w_rx_byte = r_rx_sr;
        if (w_sample) begin
            w_rx_byte = r_lsb_l ? {miso_i, r_rx_sr[7:1]} : {r_rx_sr[6:0], miso_i};
        end
    end

    assign w_rx_push    = w_last && !w_rx_full;
    assign w_rx_ovf_set = w_last && w_rx_full;
    assign w_done_set   = w_last && w_tx_empty && !w_tx_push;

    assign w_status = {r_tx_ovf, r_done, r_rx_ovf, w_rx_full,
                       w_rx_empty, w_tx_empty, w_tx_full, w_busy};

    always_comb begin
        w_rd_mux = 8'h00;
        if (port_id == c_a_ctrl)      w_rd_mux = {1'b0, r_ctrl};
        else if (port_id == c_a_div)  w_rd_mux = r_div;
        else if (port_id == c_a_cs)   w_rd_mux = {r_cs_force, 4'b0000, r_cs_sel};
        else if (port_id == c_a_stat) w_rd_mux = w_status;
        else if (port_id == c_a_data) w_rd_mux = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
    end

    // Control/status registers and bus read path
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl     <= '0;
            r_div      <= DIV_RESET;
            r_cs_sel   <= '0;
            r_cs_force <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_done     <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_data_out <= 8'h00;
            r_irq      <= 1'b0;
        end else begin
            if (write_strobe && (port_id == c_a_ctrl)) r_ctrl <= data_in[6:0];
            if (write_strobe && (port_id == c_a_div))  r_div  <= data_in;
            if (write_strobe && (port_id == c_a_cs)) begin
                r_cs_sel   <= data_in[2:0];
                r_cs_force <= data_in[7];
            end
            // Sticky flags: a set in the same cycle as a clear wins.
            if (w_tx_ovf_set)                 r_tx_ovf <= 1'b1;
            else if (w_wr_stat && data_in[7]) r_tx_ovf <= 1'b0;
            if (w_done_set)                   r_done   <= 1'b1;
            else if (w_wr_stat && data_in[6]) r_done   <= 1'b0;
            if (w_rx_ovf_set)                 r_rx_ovf <= 1'b1;
            else if (w_wr_stat && data_in[5]) r_rx_ovf <= 1'b0;
            r_irq      <= (r_ctrl[5] && r_done) || (r_ctrl[6] && !w_rx_empty);
            r_data_out <= w_rd_mux;
        end
    end

    // FIFO storage (no reset needed; occupancy is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= data_in;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= w_rx_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
        end
    end

    // Shift engine
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_tx_sr  <= '0;
            r_rx_sr  <= '0;
            r_hp_cnt <= '0;
            r_hp_idx <= '0;
            r_div_l  <= '0;
            r_cpha_l <= 1'b0;
            r_lsb_l  <= 1'b0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_sck <= r_ctrl[1];
                    // A push in this very cycle already counts, so LOAD
                    // follows the push edge directly.
                    if (r_ctrl[0] && (!w_tx_empty || w_tx_push)) r_state <= c_st_load;
                end
                c_st_load: begin
                    r_tx_sr  <= r_tx_mem[r_tx_rp];
                    r_mosi   <= r_ctrl[3] ? r_tx_mem[r_tx_rp][0] : r_tx_mem[r_tx_rp][7];
                    r_cpha_l <= r_ctrl[2];
                    r_lsb_l  <= r_ctrl[3];
                    r_div_l  <= r_div;
                    r_sck    <= r_ctrl[1];
                    r_rx_sr  <= '0;
                    r_hp_cnt <= '0;
                    r_hp_idx <= '0;
                    r_state  <= c_st_shift;
                end
                c_st_shift: begin
                    if (w_tc) begin
                        r_hp_cnt <= '0;
                        r_hp_idx <= r_hp_idx + 4'd1;
                        r_sck    <= ~r_sck;
                        if (w_last) r_state <= c_st_idle;
                    end else begin
                        r_hp_cnt <= r_hp_cnt + 8'd1;
                    end
                    if (w_sample) r_rx_sr <= w_rx_byte;
                    if (w_shift) begin
                        if (r_lsb_l) begin
                            r_tx_sr <= {1'b0, r_tx_sr[7:1]};
                            r_mosi  <= r_tx_sr[1];
                        end else begin
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                            r_mosi  <= r_tx_sr[6];
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Chip selects; SEL values beyond NCS match no output.
    always_comb begin
        ncs_o = '1;
        for (int i = 0; i < NCS; i++) begin
            if ((r_cs_sel == i[2:0]) && (r_cs_force || (r_ctrl[4] && w_busy))) ncs_o[i] = 1'b0;
        end
    end

    assign data_out  = r_data_out;
    assign interrupt = r_irq;
    assign sck_o     = r_sck;
    assign mosi_o    = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_pb_spi_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pb_spi_multi
//  Purpose  : Directed self-checking bench for pb_spi_multi. A small SPI
//             slave model returns 0x3C (or loops MOSI back to MISO).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pb_spi_multi;
    localparam logic [7:0] B = 8'h10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_id = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       read_strobe = 1'b0;
    logic       write_strobe = 1'b0;
    logic [7:0] data_out;
    logic       interrupt;
    logic       sck_o, mosi_o;
    wire        miso_i;
    logic [1:0] ncs_o;

    int n_cmp = 0;
    int n_err = 0;

    pb_spi_multi #(.BASE_ADDRESS(B), .FIFO_DEPTH(4), .NCS(2), .DIV_RESET(8'd3)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in),
        .data_out(data_out), .read_strobe(read_strobe), .write_strobe(write_strobe),
        .interrupt(interrupt), .sck_o(sck_o), .mosi_o(mosi_o), .miso_i(miso_i),
        .ncs_o(ncs_o)
    );

    always #5 clk = ~clk;

    // Slave model: counts SCK edges while selected and presents 0x3C.
    logic       loopback = 1'b1;
    logic       slv_cpha = 1'b0;
    logic       slv_lsb  = 1'b0;
    logic [7:0] slv_byte = 8'h3C;
    logic       slv_prev = 1'b0;
    int         slv_e    = 0;

    always @(sck_o or ncs_o) begin
        if (ncs_o[0]) slv_e = 0;
        else if (sck_o !== slv_prev) slv_e = (slv_e + 1) % 16;
        slv_prev = sck_o;
    end

    function automatic logic slave_bit(input int e, input logic cpha, input logic lsb,
                                       input logic [7:0] b);
        int k;
        k = cpha ? ((e == 0) ? 0 : (e - 1) / 2) : e / 2;
        if (k > 7) k = 7;
        return lsb ? b[k] : b[7 - k];
    endfunction

    assign miso_i = loopback ? mosi_o : slave_bit(slv_e, slv_cpha, slv_lsb, slv_byte);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        port_id = a; data_in = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        port_id = a;
        @(negedge clk);
        read_strobe = 1'b1;
        d = data_out;
        @(negedge clk);
        read_strobe = 1'b0;
    endtask

    // Counts cycles with ncs_o[0] low; optionally writes DIV at cycle wr_at.
    task automatic run_frame(input int wr_at, input logic [7:0] wr_val,
                             output int low, output int rises, output int half,
                             output logic [7:0] mbits);
        logic prev;
        int   changes, first_t;
        low = 0; rises = 0; half = 0; mbits = 8'h00; changes = 0; first_t = 0;
        prev = sck_o;
        while (ncs_o[0] == 1'b0 && low < 4000) begin
            low++;
            if (low == wr_at) begin
                port_id = B + 8'd1; data_in = wr_val; write_strobe = 1'b1;
            end else begin
                write_strobe = 1'b0;
            end
            @(negedge clk);
            if (sck_o != prev) begin
                changes++;
                if (changes == 1) first_t = low;
                if (changes == 2) half = low - first_t;
                if (sck_o) begin
                    rises++;
                    mbits = {mbits[6:0], mosi_o};
                end
            end
            prev = sck_o;
        end
        write_strobe = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, mb;
        int low, rises, half, edges, n;
        logic prev;
        logic [7:0] ctrl;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_data_out", data_out, 8'h00);
        check("rst_irq", interrupt, 1'b0);
        check("rst_sck", sck_o, 1'b0);
        check("rst_mosi", mosi_o, 1'b0);
        check("rst_ncs", ncs_o, 2'b11);
        cpu_read(B + 8'd3, rd); check("rst_status", rd, 8'h0C);
        cpu_read(B + 8'd0, rd); check("rst_ctrl", rd, 8'h00);
        cpu_read(B + 8'd1, rd); check("rst_div", rd, 8'h03);
        cpu_read(B + 8'd2, rd); check("rst_cs", rd, 8'h00);

        // ---- mode 0 loopback, DIV=0, AUTO_CS ----
        loopback = 1'b1;
        cpu_write(B + 8'd1, 8'h00);
        cpu_write(B + 8'd2, 8'h00);
        cpu_write(B + 8'd0, 8'h11);
        cpu_write(B + 8'd4, 8'hA5);
        run_frame(0, 8'h00, low, rises, half, mb);
        check("m0_ncs_low", low, 17);
        check("m0_rises", rises, 8);
        check("m0_mosi_bits", mb, 8'hA5);
        check("m0_ncs_after", ncs_o, 2'b11);
        cpu_read(B + 8'd3, rd); check("m0_status", rd, 8'h44);
        cpu_read(B + 8'd4, rd); check("m0_rx", rd, 8'hA5);
        cpu_read(B + 8'd3, rd); check("m0_status_empty", rd, 8'h4C);

        // ---- four modes plus LSB-first against the 0x3C slave ----
        loopback = 1'b0;
        for (int m = 0; m < 5; m++) begin
            slv_cpha = (m == 1 || m >= 3);
            slv_lsb  = (m == 4);
            ctrl = 8'h11 | ((m == 2 || m >= 3) ? 8'h02 : 8'h00)
                         | (slv_cpha ? 8'h04 : 8'h00) | (slv_lsb ? 8'h08 : 8'h00);
            cpu_write(B + 8'd0, ctrl);
            @(negedge clk); @(negedge clk);
            check($sformatf("mode%0d_sck_idle_pre", m), sck_o, ctrl[1]);
            cpu_write(B + 8'd4, 8'h81);
            run_frame(0, 8'h00, low, rises, half, mb);
            check($sformatf("mode%0d_ncs_low", m), low, 17);
            check($sformatf("mode%0d_sck_idle_post", m), sck_o, ctrl[1]);
            cpu_read(B + 8'd4, rd);
            check($sformatf("mode%0d_rx", m), rd, 8'h3C);
        end

        // ---- FIFO overflow, back-to-back frames, RX overflow ----
        loopback = 1'b1;
        cpu_write(B + 8'd0, 8'h00);
        cpu_write(B + 8'd3, 8'hE0);
        cpu_read(B + 8'd3, rd); check("ovf_status_clr0", rd, 8'h0C);
        for (int i = 1; i <= 5; i++) cpu_write(B + 8'd4, 8'(i));
        cpu_read(B + 8'd3, rd); check("ovf_tx_status", rd, 8'h8A);
        cpu_write(B + 8'd0, 8'h11);
        run_frame(0, 8'h00, low, rises, half, mb);
        check("b2b_ncs_low", low, 72);
        cpu_read(B + 8'd3, rd); check("b2b_status", rd, 8'hD4);
        cpu_write(B + 8'd4, 8'h55);
        run_frame(0, 8'h00, low, rises, half, mb);
        check("rxovf_ncs_low", low, 17);
        cpu_read(B + 8'd3, rd); check("rxovf_status", rd, 8'hF4);
        cpu_write(B + 8'd3, 8'hE0);
        cpu_read(B + 8'd3, rd); check("sticky_clear", rd, 8'h14);
        for (int i = 1; i <= 4; i++) begin
            cpu_read(B + 8'd4, rd);
            check($sformatf("rx_drain%0d", i), rd, 32'(i));
        end
        cpu_read(B + 8'd3, rd); check("drained_status", rd, 8'h0C);
        cpu_read(B + 8'd4, rd); check("pop_empty", rd, 8'h00);
        cpu_read(B + 8'd3, rd); check("pop_empty_status", rd, 8'h0C);

        // ---- divider: DIV=2, then change DIV mid-frame ----
        cpu_write(B + 8'd1, 8'h02);
        cpu_write(B + 8'd4, 8'h5A);
        run_frame(0, 8'h00, low, rises, half, mb);
        check("div2_ncs_low", low, 49);
        check("div2_half", half, 3);
        check("div2_rises", rises, 8);
        cpu_write(B + 8'd4, 8'hC3);
        run_frame(10, 8'h00, low, rises, half, mb);
        check("div_midwr_frame", low, 49);
        cpu_read(B + 8'd1, rd); check("div_midwr_reg", rd, 8'h00);
        cpu_write(B + 8'd4, 8'h96);
        run_frame(0, 8'h00, low, rises, half, mb);
        check("div0_next_frame", low, 17);
        cpu_read(B + 8'd4, rd); check("div_rx1", rd, 8'h5A);
        cpu_read(B + 8'd4, rd); check("div_rx2", rd, 8'hC3);
        cpu_read(B + 8'd4, rd); check("div_rx3", rd, 8'h96);

        // ---- reset mid-frame after 5 SCK edges ----
        cpu_write(B + 8'd1, 8'h02);
        cpu_write(B + 8'd4, 8'h77);
        cpu_write(B + 8'd4, 8'h78);
        prev = sck_o; edges = 0; n = 0;
        while (edges < 5 && n < 300) begin
            @(negedge clk);
            n++;
            if (sck_o != prev) edges++;
            prev = sck_o;
        end
        check("mid_edges", edges, 5);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_sck", sck_o, 1'b0);
        check("mid_rst_ncs", ncs_o, 2'b11);
        check("mid_rst_mosi", mosi_o, 1'b0);
        reset = 1'b0;
        cpu_read(B + 8'd3, rd); check("mid_rst_status", rd, 8'h0C);
        cpu_read(B + 8'd1, rd); check("mid_rst_div", rd, 8'h03);

        // ---- RX interrupt and unmapped reads ----
        cpu_write(B + 8'd1, 8'h00);
        cpu_write(B + 8'd0, 8'h51);
        cpu_write(B + 8'd4, 8'h33);
        run_frame(0, 8'h00, low, rises, half, mb);
        check("irq_ncs_low", low, 17);
        check("irq_pre", interrupt, 1'b0);
        @(negedge clk);
        check("irq_rise", interrupt, 1'b1);
        cpu_read(B + 8'd4, rd);
        check("irq_rx", rd, 8'h33);
        check("irq_hold", interrupt, 1'b1);
        @(negedge clk);
        check("irq_fall", interrupt, 1'b0);
        cpu_read(B + 8'd5, rd); check("unmapped_hi", rd, 8'h00);
        cpu_read(B - 8'd1, rd); check("unmapped_lo", rd, 8'h00);

        // ---- forced chip selects ----
        cpu_write(B + 8'd2, 8'h81); check("force_sel1", ncs_o, 2'b01);
        cpu_write(B + 8'd2, 8'h80); check("force_sel0", ncs_o, 2'b10);
        cpu_write(B + 8'd2, 8'h85); check("force_sel5", ncs_o, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
